// File: rtl/exc_pkg.sv
// Shared definitions for the exception dispatch block.
//
// Contents:
//   - exception code constants written by writeback into rstatus
//   - dispatch FSM state encoding
//   - FIFO entry layout {code, pc}
//   - vector_addr(): handler vector address for a code (wraps mod 2^32)
package exc_pkg;

  localparam logic [4:0] EXC_NONE     = 5'd0;
  localparam logic [4:0] EXC_ADD_OVF  = 5'd1;
  localparam logic [4:0] EXC_ADDI_OVF = 5'd2;
  localparam logic [4:0] EXC_SUB_OVF  = 5'd3;
  localparam logic [4:0] RSTATUS_IDX  = 5'd30;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HANDLER  = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
  } exc_entry_t;

  // Each vector slot is one word, so the code is scaled by 4.
  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [4:0]  code);
    return base + {25'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/exc_fifo.sv
// Synchronous event FIFO for exception_dispatch.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset (empties the FIFO)
//   push        write push_entry this cycle
//   push_entry  entry to write
//   pop         remove the head entry this cycle
//   full        DEPTH entries held
//   empty       no entries held
//   head        oldest entry, all zeros while empty
//
// A push while full is accepted only when a pop happens in the same cycle;
// the freed slot is the one being written, so occupancy stays at DEPTH.
// A pop while empty is ignored.
module exc_fifo
  import exc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  exc_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output exc_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  exc_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/exception_dispatch.sv
// Exception dispatch: snoops writeback writes to the rstatus register,
// queues each nonzero overflow code with its faulting PC, and redirects
// fetch to the per-code handler vector with a valid/ready handshake. One
// handler runs at a time; eret releases the next queued event.
//
// Ports:
//   clock, reset        system clock / asynchronous active-low reset
//   wb_we, wb_dest,     writeback register write being snooped
//   wb_data, wb_pc
//   eret                handler return pulse from decode
//   exc_valid           redirect request to fetch
//   exc_ready           fetch accepts the redirect
//   exc_code            code of the head event (0 while queue empty)
//   exc_target          HANDLER_BASE + exc_code*4 (0 while queue empty)
//   exc_epc             faulting PC of the head event (0 while queue empty)
//   in_handler          a handler is executing
//   drop_cnt            saturating count of events lost to a full queue
//   rstatus_q           last nonzero value written to the status register
//
// Optional build macro EXC_COUNT_EN adds cnt_add / cnt_addi / cnt_sub,
// 16-bit saturating counts of accepted events per overflow code.
//
// FSM states:
//   IDLE     | no handler active, waiting for a queued event
//   REDIRECT | exc_valid asserted, head held until fetch accepts
//   HANDLER  | handler running, waiting for eret
module exception_dispatch
  import exc_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0100,
  parameter logic [4:0]  STATUS_REG   = RSTATUS_IDX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        eret,
  output logic        exc_valid,
  input  logic        exc_ready,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_target,
  output logic [31:0] exc_epc,
  output logic        in_handler,
  output logic [7:0]  drop_cnt,
  output logic [31:0] rstatus_q
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] cnt_add,
  output logic [15:0] cnt_addi,
  output logic [15:0] cnt_sub
`endif
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_REDIRECT = REDIRECT;
  localparam logic [1:0] S_HANDLER  = HANDLER;

  logic [1:0]  state;
  logic        exc_event;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  exc_entry_t  push_entry;
  exc_entry_t  head;

  assign exc_event  = wb_we && (wb_dest == STATUS_REG) && (wb_data[4:0] != EXC_NONE);
  assign push_entry = '{code: wb_data[4:0], pc: wb_pc};

  // The queue is never empty in REDIRECT, so acceptance always pops.
  assign fifo_pop   = (state == S_REDIRECT) && exc_ready;

  exc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (exc_event),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (!fifo_empty) state <= S_REDIRECT;
        S_REDIRECT: if (exc_ready)   state <= S_HANDLER;
        S_HANDLER:  if (eret)        state <= S_IDLE;
        default:                     state <= S_IDLE;
      endcase
    end
  end

  assign exc_valid  = (state == S_REDIRECT);
  assign in_handler = (state == S_HANDLER);
  assign exc_code   = head.code;
  assign exc_epc    = head.pc;
  assign exc_target = fifo_empty ? 32'h0 : vector_addr(HANDLER_BASE, head.code);

  // rstatus_q follows every event, including ones dropped by a full queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstatus_q <= '0;
      drop_cnt  <= '0;
    end else begin
      if (exc_event) begin
        rstatus_q <= wb_data;
      end
      if (exc_event && fifo_full && !fifo_pop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef EXC_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_add  <= '0;
      cnt_addi <= '0;
      cnt_sub  <= '0;
    end else if (fifo_pop) begin
      if (head.code == EXC_ADD_OVF && cnt_add != 16'hFFFF) begin
        cnt_add <= cnt_add + 16'd1;
      end
      if (head.code == EXC_ADDI_OVF && cnt_addi != 16'hFFFF) begin
        cnt_addi <= cnt_addi + 16'd1;
      end
      if (head.code == EXC_SUB_OVF && cnt_sub != 16'hFFFF) begin
        cnt_sub <= cnt_sub + 16'd1;
      end
    end
  end
`endif

endmodule
